// File: rtl/decode_sequencer_pkg.sv
// Shared definitions for the 6502 decode sequencer: field codes, write-enable bits,
// selector codes, FSM encoding and the per-step control word builders.
package decode_sequencer_pkg;

    localparam int OP_W       = 8;
    localparam int ADDR_W     = 16;
    localparam int OPP_W      = 5;
    localparam int WE_W       = 10;
    localparam int SEL_FIELDS = 10;
    localparam int SEL_W      = 4;
    localparam int SEL_BUS_W  = SEL_FIELDS * SEL_W;

    // opp = {aaa, cc} for the cc=01 group
    localparam logic [4:0] OPP_ORA = 5'b000_01;
    localparam logic [4:0] OPP_AND = 5'b001_01;
    localparam logic [4:0] OPP_EOR = 5'b010_01;
    localparam logic [4:0] OPP_ADC = 5'b011_01;
    localparam logic [4:0] OPP_STA = 5'b100_01;
    localparam logic [4:0] OPP_LDA = 5'b101_01;
    localparam logic [4:0] OPP_CMP = 5'b110_01;
    localparam logic [4:0] OPP_SBC = 5'b111_01;

    localparam logic [2:0] AM_ZPX_IND  = 3'b000;
    localparam logic [2:0] AM_ZP       = 3'b001;
    localparam logic [2:0] AM_IMM      = 3'b010;
    localparam logic [2:0] AM_ABS      = 3'b011;
    localparam logic [2:0] AM_ZP_IND_Y = 3'b100;
    localparam logic [2:0] AM_ZPX      = 3'b101;
    localparam logic [2:0] AM_ABS_Y    = 3'b110;
    localparam logic [2:0] AM_ABS_X    = 3'b111;

    localparam int WE_PC   = 0;
    localparam int WE_SP   = 1;
    localparam int WE_ADD  = 2;
    localparam int WE_X    = 3;
    localparam int WE_Y    = 4;
    localparam int WE_STAT = 5;
    localparam int WE_A    = 6;
    localparam int WE_DOUT = 7;
    localparam int WE_IR   = 8;
    localparam int WE_PTR  = 9;

    // Selector field positions; A has no field of its own and loads through the ALU's first port.
    localparam int SF_PC     = 0;
    localparam int SF_SP     = 1;
    localparam int SF_ADD    = 2;
    localparam int SF_X      = 3;
    localparam int SF_Y      = 4;
    localparam int SF_STAT   = 5;
    localparam int SF_MEM    = 6;
    localparam int SF_DECODE = 7;
    localparam int SF_ALU0   = 8;
    localparam int SF_ALU1   = 9;

    typedef enum logic [3:0] {
        SEL_NONE   = 4'd0,
        SEL_IMM    = 4'd1,
        SEL_IMM_HI = 4'd2,
        SEL_MEM    = 4'd3,
        SEL_ADD    = 4'd4,
        SEL_X      = 4'd5,
        SEL_Y      = 4'd6,
        SEL_A      = 4'd7,
        SEL_ALU    = 4'd8,
        SEL_ALU_ZP = 4'd9
    } sel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_IND   = 3'd2,
        ST_INDEX = 3'd3,
        ST_EXEC  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] n_bytes;
        logic       indirect;
        logic       idx_x;
        logic       idx_y;
        logic       zp_wrap;
    } am_info_t;

    typedef struct packed {
        logic [WE_W-1:0]      we;
        logic [SEL_BUS_W-1:0] sel;
        logic                 pc_inc;
    } ctrl_t;

    function automatic logic is_illegal(input logic [7:0] op);
        return (op[1:0] != 2'b01) || (op == 8'h89);
    endfunction

    function automatic state_t next_after(input state_t st, input am_info_t am);
        state_t nxt;
        case (st)
            ST_FETCH: nxt = am.indirect ? ST_IND :
                            (am.idx_x || am.idx_y) ? ST_INDEX : ST_EXEC;
            ST_IND:   nxt = (am.idx_x || am.idx_y) ? ST_INDEX : ST_EXEC;
            ST_INDEX: nxt = ST_EXEC;
            ST_EXEC:  nxt = ST_DONE;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Control word for one step; hi selects the second operand byte in FETCH.
    function automatic ctrl_t step_ctrl(input state_t st, input logic hi,
                                        input logic [7:0] op, input am_info_t am);
        ctrl_t c;
        sel_t  operand;
        c = '0;
        operand = (op[4:2] == AM_IMM) ? SEL_IMM : SEL_MEM;
        case (st)
            ST_FETCH: begin
                c.pc_inc = 1'b1;
                c.we[WE_ADD] = 1'b1;
                c.sel[SF_ADD*SEL_W +: SEL_W] = hi ? SEL_IMM_HI : SEL_IMM;
            end
            ST_IND: begin
                c.we[WE_ADD] = 1'b1;
                c.sel[SF_ADD*SEL_W +: SEL_W] = SEL_MEM;
            end
            ST_INDEX: begin
                c.we[WE_ADD] = 1'b1;
                c.sel[SF_ALU0*SEL_W +: SEL_W] = SEL_ADD;
                c.sel[SF_ALU1*SEL_W +: SEL_W] = am.idx_y ? SEL_Y : SEL_X;
                c.sel[SF_ADD*SEL_W +: SEL_W]  = am.zp_wrap ? SEL_ALU_ZP : SEL_ALU;
            end
            ST_EXEC: begin
                case ({op[7:5], op[1:0]})
                    OPP_STA: begin
                        c.we[WE_DOUT] = 1'b1;
                        c.sel[SF_MEM*SEL_W +: SEL_W] = SEL_A;
                    end
                    OPP_LDA: begin
                        c.we[WE_A] = 1'b1;
                        c.sel[SF_ALU0*SEL_W +: SEL_W] = operand;
                    end
                    OPP_CMP: begin
                        c.we[WE_STAT] = 1'b1;
                        c.sel[SF_ALU0*SEL_W +: SEL_W] = SEL_A;
                        c.sel[SF_ALU1*SEL_W +: SEL_W] = operand;
                    end
                    default: begin
                        c.we[WE_A]    = 1'b1;
                        c.we[WE_STAT] = 1'b1;
                        c.sel[SF_ALU0*SEL_W +: SEL_W] = SEL_A;
                        c.sel[SF_ALU1*SEL_W +: SEL_W] = operand;
                    end
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_sequencer_addr_mode_rom.sv
// Combinational addressing-mode table: maps the bbb field to the steps the
// sequencer must walk through.
module decode_sequencer_addr_mode_rom
    import decode_sequencer_pkg::*;
(
    input  logic [2:0] bbb,
    output logic [1:0] n_bytes,
    output logic       indirect,
    output logic       idx_x,
    output logic       idx_y,
    output logic       zp_wrap
);

    assign n_bytes  = (bbb inside {AM_ABS, AM_ABS_Y, AM_ABS_X}) ? 2'd2 : 2'd1;
    assign indirect = bbb inside {AM_ZPX_IND, AM_ZP_IND_Y};
    assign idx_x    = bbb inside {AM_ZPX_IND, AM_ZPX, AM_ABS_X};
    assign idx_y    = bbb inside {AM_ZP_IND_Y, AM_ABS_Y};
    // (zp),Y adds Y to a full 16-bit pointer, so only the X zero-page forms wrap
    assign zp_wrap  = bbb inside {AM_ZPX_IND, AM_ZPX};

endmodule

// File: rtl/decode_sequencer.sv
// Multi-cycle 6502 instruction sequencer: accepts an opcode, then steps
// FETCH -> [IND] -> [INDEX] -> EXEC -> DONE driving write-enables and selectors.
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int REG_WIDTH = OP_W,
    parameter int OPP_WIDTH = OPP_W,
    parameter int WE_WIDTH  = WE_W,
    parameter int NUM_SEL   = SEL_FIELDS,
    parameter int SEL_WIDTH = SEL_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           instr_valid,
    input  logic [REG_WIDTH-1:0]           instr_in,
    output logic                           instr_ready,
    input  logic                           stall,
    output logic [OPP_WIDTH-1:0]           opp,
    output logic [WE_WIDTH-1:0]            we,
    output logic [NUM_SEL*SEL_WIDTH-1:0]   sel_bus,
    output logic                           pc_inc,
    output logic                           instr_done,
    output logic                           err_illegal
);

    state_t               state;
    state_t               nxt;
    logic                 step_cnt;
    logic                 nxt_cnt;
    logic [REG_WIDTH-1:0] ir;
    logic [REG_WIDTH-1:0] cur_op;
    logic [OPP_WIDTH-1:0] opp_q;
    ctrl_t                ctrl_q;
    logic                 done_q;
    logic                 err_q;

    logic [1:0] am_n_bytes;
    logic       am_indirect;
    logic       am_idx_x;
    logic       am_idx_y;
    logic       am_zp_wrap;
    am_info_t   am;

    // In IDLE the incoming byte is decoded so the first step's controls are ready at accept.
    assign cur_op = (state == ST_IDLE) ? instr_in : ir;

    decode_sequencer_addr_mode_rom u_rom (
        .bbb      (cur_op[4:2]),
        .n_bytes  (am_n_bytes),
        .indirect (am_indirect),
        .idx_x    (am_idx_x),
        .idx_y    (am_idx_y),
        .zp_wrap  (am_zp_wrap)
    );

    assign am = {am_n_bytes, am_indirect, am_idx_x, am_idx_y, am_zp_wrap};

    always_comb begin
        // NOTE: defaults first so no path through the case leaves nxt/nxt_cnt unassigned (no latch).
        nxt     = state;
        nxt_cnt = step_cnt;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    nxt     = is_illegal(instr_in) ? ST_DONE : ST_FETCH;
                    nxt_cnt = 1'b0;
                end
            end
            ST_FETCH: begin
                if (!stall) begin
                    if (!step_cnt && am.n_bytes == 2'd2) begin
                        nxt_cnt = 1'b1;
                    end else begin
                        nxt     = next_after(state, am);
                        nxt_cnt = 1'b0;
                    end
                end
            end
            ST_IND: begin
                if (!stall) begin
                    if (!step_cnt) begin
                        nxt_cnt = 1'b1;
                    end else begin
                        nxt     = next_after(state, am);
                        nxt_cnt = 1'b0;
                    end
                end
            end
            ST_INDEX, ST_EXEC: begin
                if (!stall) nxt = next_after(state, am);
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered against the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only; every register has a reset value.
        if (!reset_n) begin
            state    <= ST_IDLE;
            step_cnt <= 1'b0;
            ir       <= '0;
            opp_q    <= '0;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= nxt;
            step_cnt <= nxt_cnt;
            ctrl_q   <= step_ctrl(nxt, nxt_cnt, cur_op, am);
            done_q   <= (nxt == ST_DONE);
            err_q    <= (state == ST_IDLE) && (nxt == ST_DONE);
            if (state == ST_IDLE && instr_valid) begin
                ir    <= instr_in;
                opp_q <= {instr_in[7:5], instr_in[1:0]};
            end
        end
    end

    assign instr_ready = (state == ST_IDLE);
    assign opp         = opp_q;
    assign sel_bus     = ctrl_q.sel;
    // A stalled step must not commit; the held state replays it once stall drops.
    assign we          = ctrl_q.we & {WE_WIDTH{~stall}};
    assign pc_inc      = ctrl_q.pc_inc & ~stall;
    assign instr_done  = done_q;
    assign err_illegal = err_q;

endmodule
